deser_word_align: RTL and testbench

//  Receive-side word aligner, the counterpart of the team's 10:1 LVDS serializer.

---
 rtl/deser_align_pkg.sv | 27 ++
 rtl/deser_word_align_comma_search.sv | 29 ++
 rtl/deser_word_align.sv | 161 ++++++++++++++++
 tb/tb_deser_word_align.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_align_pkg.sv
// Shared types and constants for the receive-side word aligner.
// K28.5 symbols are given in stream order: bit0 is the first bit on the wire.
package deser_align_pkg;

   localparam int unsigned WORD_W = 10;
   localparam int unsigned WIN_W  = 2 * WORD_W;
   localparam int unsigned OFF_W  = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
   localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   // Word starting k bits into the two-word window {newest, previous}.
   function automatic logic [WORD_W-1:0] window_slice(input logic [WIN_W-1:0] w,
                                                      input logic [OFF_W-1:0] k);
      logic [WIN_W-1:0] shifted;
      shifted = w >> k;
      return shifted[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/deser_word_align_comma_search.sv
// Combinational comma finder over a 20-bit window; reports the lowest matching offset.
module comma_search
   import deser_align_pkg::*;
#(
   parameter logic [WORD_W-1:0] SYNC_WORD = K28_5_RDN,
   parameter bit                MATCH_INV = 1'b1
) (
   input  logic [WIN_W-1:0] w,
   output logic             hit_c,
   output logic [OFF_W-1:0] k_c
);

   logic [WORD_W-1:0] cand;

   // Scan from the highest offset down so the lowest matching offset is the last writer.
   always_comb begin
      hit_c = 1'b0;
      k_c   = '0;
      cand  = '0;
      for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
         cand = window_slice(w, OFF_W'(i));
         if ((cand == SYNC_WORD) || (MATCH_INV && (cand == ~SYNC_WORD))) begin
            hit_c = 1'b1;
            k_c   = OFF_W'(i);
         end
      end
   end

endmodule

// File: rtl/deser_word_align.sv
// Receive word aligner: hunts for K28.5 in the raw 1:10 deserializer stream,
// locks the bit offset and emits word-aligned data one cycle after each valid word.
module deser_word_align
   import deser_align_pkg::*;
#(
   parameter int unsigned      WIDTH     = 10,
   parameter logic [WIDTH-1:0] SYNC_WORD = K28_5_RDN,
   parameter bit               MATCH_INV = 1'b1,
   parameter int unsigned      LOCK_CNT  = 4,
   parameter int unsigned      SLIP_CNT  = 3
) (
   input  logic             clk_i,
   input  logic             a_rst_n_i,
   input  logic [WIDTH-1:0] raw_data_i,
   input  logic             raw_valid_i,
   input  logic             realign_i,
   output logic [WIDTH-1:0] p_data_o,
   output logic             p_valid_o,
   output logic             locked_o,
   output logic [OFF_W-1:0] offset_o
);

   align_state_e         state_q;
   align_state_e         state_d;
   logic [WIDTH-1:0]     prev_q;
   logic [2*WIDTH-1:0]   win;
   logic                 hit_c;
   logic [OFF_W-1:0]     k_c;
   logic                 at_offset_c;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [CNT_W-1:0]     cnt_inc_c;
   logic [CNT_W-1:0]     miss_q;
   logic [CNT_W-1:0]     miss_d;
   logic [CNT_W-1:0]     miss_inc_c;
   logic [OFF_W-1:0]     offset_q;
   logic [OFF_W-1:0]     offset_d;
   logic [WIDTH-1:0]     p_data_d;
   logic                 p_valid_d;
   logic                 locked_d;

   assign win         = {raw_data_i, prev_q};
   assign at_offset_c = hit_c && (k_c == offset_q);
   assign cnt_inc_c   = cnt_q + CNT_W'(1);
   assign miss_inc_c  = miss_q + CNT_W'(1);
   assign offset_o    = offset_q;

   comma_search #(
      .SYNC_WORD (SYNC_WORD),
      .MATCH_INV (MATCH_INV)
   ) u_comma_search (
      .w     (win),
      .hit_c (hit_c),
      .k_c   (k_c)
   );

   // State register.
   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Window history, lock/slip counters and locked offset.
   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         prev_q   <= '0;
         cnt_q    <= '0;
         miss_q   <= '0;
         offset_q <= '0;
      end else begin
         if (raw_valid_i) begin
            prev_q <= raw_data_i;
         end
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
         offset_q <= offset_d;
      end
   end

   // Next state: only valid words advance the FSM; realign overrides everything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      miss_d   = miss_q;
      offset_d = offset_q;
      if (raw_valid_i) begin
         unique case (state_q)
            HUNT: begin
               if (hit_c) begin
                  offset_d = k_c;
                  cnt_d    = CNT_W'(1);
                  state_d  = VERIFY;
               end
            end
            VERIFY: begin
               if (at_offset_c) begin
                  if (cnt_inc_c == CNT_W'(LOCK_CNT)) begin
                     cnt_d   = '0;
                     state_d = LOCKED;
                  end else begin
                     cnt_d = cnt_inc_c;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (at_offset_c) begin
                  miss_d = '0;
               end else if (hit_c) begin
                  if (miss_inc_c == CNT_W'(SLIP_CNT)) begin
                     miss_d  = '0;
                     state_d = HUNT;
                  end else begin
                     miss_d = miss_inc_c;
                  end
               end
            end
            default: begin
               cnt_d   = '0;
               miss_d  = '0;
               state_d = HUNT;
            end
         endcase
      end
      if (realign_i) begin
         cnt_d   = '0;
         miss_d  = '0;
         state_d = HUNT;
      end
   end

   // Output next values; data uses the offset held before this word's update.
   always_comb begin
      p_data_d  = p_data_o;
      p_valid_d = 1'b0;
      locked_d  = (state_d == LOCKED);
      if (raw_valid_i) begin
         p_data_d  = window_slice(win, offset_q);
         p_valid_d = (state_q == LOCKED) && !realign_i;
      end
   end

   // Output registers.
   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         p_data_o  <= '0;
         p_valid_o <= 1'b0;
         locked_o  <= 1'b0;
      end else begin
         p_data_o  <= p_data_d;
         p_valid_o <= p_valid_d;
         locked_o  <= locked_d;
      end
   end

endmodule

// File: tb/tb_deser_word_align.sv
// Bench for deser_word_align: directed K28.5 bitstreams at chosen bit offsets,
// emitted words scored through an expected-data queue by an independent monitor.
module tb_deser_word_align;

   localparam logic [9:0] C = 10'h17C;
   localparam logic [9:0] P = 10'h155;
   localparam logic [9:0] Z = 10'h000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] raw_data = '0;
   logic       raw_valid = 1'b0;
   logic       realign = 1'b0;
   logic [9:0] p_data;
   logic       p_valid;
   logic       locked;
   logic [3:0] offset;

   int tests = 0;
   int fails = 0;
   int mon_tests = 0;
   int mon_fails = 0;

   logic [9:0] exp_q[$];
   logic [9:0] m_exp;
   logic [9:0] last_sym = '0;
   logic [9:0] prev_raw = '0;

   always #5 clk = ~clk;

   deser_word_align dut (
      .clk_i       (clk),
      .a_rst_n_i   (rst_n),
      .raw_data_i  (raw_data),
      .raw_valid_i (raw_valid),
      .realign_i   (realign),
      .p_data_o    (p_data),
      .p_valid_o   (p_valid),
      .locked_o    (locked),
      .offset_o    (offset)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Serialise symbol `sym` so its bit0 lands at word bit `o`; when `emit` is set the
   // aligner is expected (hand-scripted) to be locked at `exp_off` for this word.
   task automatic send(input logic [9:0] sym, input int unsigned o, input bit emit,
                       input int unsigned exp_off, input bit rl = 1'b0);
      logic [19:0] t;
      logic [9:0]  raw;
      t   = {sym, last_sym} >> (10 - o);
      raw = t[9:0];
      @(negedge clk);
      raw_data  = raw;
      raw_valid = 1'b1;
      realign   = rl;
      if (emit) begin
         t = {raw, prev_raw} >> exp_off;
         exp_q.push_back(t[9:0]);
      end
      last_sym = sym;
      prev_raw = raw;
   endtask

   task automatic idle();
      @(negedge clk);
      raw_valid = 1'b0;
      realign   = 1'b0;
      raw_data  = 10'($urandom);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n     = 1'b0;
      raw_valid = 1'b0;
      realign   = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      last_sym = '0;
      prev_raw = '0;
   endtask

   // Monitor: every emitted word must match the oldest expected entry.
   always @(posedge clk) begin
      #1;
      if (rst_n && p_valid) begin
         mon_tests++;
         if (exp_q.size() == 0) begin
            mon_fails++;
            $display("FAIL unexpected_word: got 0x%0h, want no output", p_data);
         end else begin
            m_exp = exp_q.pop_front();
            if (p_data !== m_exp) begin
               mon_fails++;
               $display("FAIL aligned_word: got 0x%0h, want 0x%0h", p_data, m_exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      // Reset held while random words stream in.
      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         raw_valid = 1'b1;
         raw_data  = 10'($urandom);
         settle();
         chk("rst_p_data", 32'(p_data), 32'h0);
         chk("rst_p_valid", 32'(p_valid), 32'h0);
         chk("rst_locked", 32'(locked), 32'h0);
         chk("rst_offset", 32'(offset), 32'h0);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      raw_valid = 1'b0;
      settle();
      chk("post_rst_locked", 32'(locked), 32'h0);

      // Lock at offset 3; the first comma is only fully visible in the second word.
      reset_dut();
      send(C, 3, 0, 3);
      send(C, 3, 0, 3);
      settle();
      chk("lock_offset", 32'(offset), 32'd3);
      chk("lock_not_yet", 32'(locked), 32'h0);
      send(C, 3, 0, 3);
      send(C, 3, 0, 3);
      settle();
      chk("lock_before_4th", 32'(locked), 32'h0);
      send(C, 3, 0, 3);
      settle();
      chk("lock_after_4th", 32'(locked), 32'h1);
      send(P, 3, 1, 3);
      send(C, 3, 1, 3);
      settle();
      chk("payload_data", 32'(p_data), 32'h155);
      chk("payload_valid", 32'(p_valid), 32'h1);
      send(C, 3, 1, 3);

      // Two commas then a non-comma drop back to HUNT.
      reset_dut();
      send(C, 3, 0, 3);
      send(C, 3, 0, 3);
      send(Z, 3, 0, 3);
      send(Z, 3, 0, 3);
      settle();
      chk("break_locked", 32'(locked), 32'h0);
      for (int i = 0; i < 4; i++) send(C, 3, 0, 3);
      settle();
      chk("break_relock_early", 32'(locked), 32'h0);
      send(C, 3, 0, 3);
      settle();
      chk("break_relock", 32'(locked), 32'h1);

      // Slip: misplaced commas at offset 5.
      reset_dut();
      for (int i = 0; i < 5; i++) send(C, 3, 0, 3);
      settle();
      chk("slip_locked3", 32'(locked), 32'h1);
      send(C, 3, 1, 3);
      send(C, 5, 1, 3);
      send(C, 5, 1, 3);
      send(C, 5, 1, 3);
      settle();
      chk("slip_two_miss", 32'(locked), 32'h1);
      send(C, 3, 1, 3);
      send(C, 3, 1, 3);
      send(C, 5, 1, 3);
      send(C, 5, 1, 3);
      send(C, 5, 1, 3);
      settle();
      chk("slip_miss_cleared", 32'(locked), 32'h1);
      send(C, 5, 1, 3);
      settle();
      chk("slip_unlock", 32'(locked), 32'h0);
      for (int i = 0; i < 3; i++) send(C, 5, 0, 5);
      settle();
      chk("slip_offset5", 32'(offset), 32'd5);
      chk("slip_relock_early", 32'(locked), 32'h0);
      send(C, 5, 0, 5);
      settle();
      chk("slip_relock", 32'(locked), 32'h1);
      send(P, 5, 1, 5);
      send(C, 5, 1, 5);
      settle();
      chk("slip_payload", 32'(p_data), 32'h155);

      // Realign on the would-be locking comma, then again while locked.
      reset_dut();
      for (int i = 0; i < 4; i++) send(C, 3, 0, 3);
      send(C, 3, 0, 3, 1'b1);
      settle();
      chk("realign_no_lock", 32'(locked), 32'h0);
      chk("realign_no_valid", 32'(p_valid), 32'h0);
      for (int i = 0; i < 3; i++) send(C, 3, 0, 3);
      settle();
      chk("realign_cnt_cleared", 32'(locked), 32'h0);
      send(C, 3, 0, 3);
      settle();
      chk("realign_relock", 32'(locked), 32'h1);
      send(C, 3, 0, 3, 1'b1);
      settle();
      chk("realign_locked_valid", 32'(p_valid), 32'h0);
      chk("realign_locked_drop", 32'(locked), 32'h0);

      // Gaps: only valid words count toward lock.
      reset_dut();
      send(C, 3, 0, 3);
      idle();
      send(C, 3, 0, 3);
      idle();
      idle();
      send(C, 3, 0, 3);
      idle();
      send(C, 3, 0, 3);
      idle();
      idle();
      settle();
      chk("gap_not_locked", 32'(locked), 32'h0);
      send(C, 3, 0, 3);
      settle();
      chk("gap_locked", 32'(locked), 32'h1);
      idle();
      settle();
      chk("gap_idle_valid", 32'(p_valid), 32'h0);
      send(P, 3, 1, 3);
      send(C, 3, 1, 3);
      idle();
      settle();
      chk("gap_hold_data", 32'(p_data), 32'h155);

      // Asynchronous reset mid-VERIFY clears everything at once.
      reset_dut();
      send(C, 3, 0, 3);
      send(C, 3, 0, 3);
      send(C, 3, 0, 3);
      settle();
      chk("midrst_pre_offset", 32'(offset), 32'd3);
      chk("midrst_pre_data", 32'(p_data), 32'h17C);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data", 32'(p_data), 32'h0);
      chk("midrst_offset", 32'(offset), 32'h0);
      chk("midrst_locked", 32'(locked), 32'h0);
      chk("midrst_valid", 32'(p_valid), 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      raw_valid = 1'b0;
      last_sym  = '0;
      prev_raw  = '0;

      repeat (3) idle();
      settle();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_words: got %0d pending, want 0", exp_q.size());
      end
      tests += mon_tests;
      fails += mon_fails;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
